conv_window_ctrl: RTL and testbench
===================================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter KERNEL_SIZE, default 3, window edge length.
REQ-002 Parameter IMG_W, default 32, pixels per row (>= KERNEL_SIZE).
REQ-003 Parameter IMG_H, default 32, rows per frame (>= KERNEL_SIZE).
REQ-004 Parameter CNT_W, default 16, width of the row and column counters.
REQ-005 Port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port start, input, 1, frame start pulse; honoured only in IDLE.
REQ-008 Port abort, input, 1, synchronous frame abort.
REQ-009 Port s_valid, input, 1, upstream pixel valid.
REQ-010 Port s_ready, output, 1, upstream pixel ready (combinational).
REQ-011 Port lb_shift_en, output, 1, line-buffer shift enable, equal to s_valid && s_ready.
REQ-012 Port win_valid, output, 1, line-buffer window holds a complete in-image kernel window.
REQ-013 Port m_ready, input, 1, downstream window accept.
REQ-014 Port col_idx, output, CNT_W, column of the next pixel to be accepted.
REQ-015 Port row_idx, output, CNT_W, row of the next pixel to be accepted.
REQ-016 Port busy, output, 1, high in RUN or FLUSH.
REQ-017 Port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-018 States: IDLE, RUN, FLUSH; encoding is free.
REQ-019 IDLE -> RUN on start: clears col_idx, row_idx and win_valid.
REQ-020 s_ready = (state==RUN) && !(win_valid && !m_ready); s_ready is 0 in IDLE and FLUSH.
REQ-021 On accept, col_idx increments; at IMG_W-1 it wraps to 0 and row_idx increments.
REQ-022 win_valid is registered: set on the cycle after an accept at row_idx >= KERNEL_SIZE-1 and col_idx >= KERNEL_SIZE-1; this aligns with the line-buffer output update.
REQ-023 Once set, win_valid holds until a cycle with m_ready=1; it then clears, unless a new qualifying accept occurs in that same cycle, in which case it stays set.
REQ-024 While win_valid && !m_ready, no shift occurs, so the window stays stable.
REQ-025 Accept of pixel (IMG_H-1, IMG_W-1) moves RUN -> FLUSH; counters wrap to (0,0).
REQ-026 FLUSH -> IDLE on the cycle win_valid && m_ready; done pulses high in that cycle.
REQ-027 Frame windows total (IMG_W-KERNEL_SIZE+1)*(IMG_H-KERNEL_SIZE+1); no window is emitted across a row wrap.
REQ-028 start outside IDLE is ignored.
REQ-029 abort in any state forces IDLE next cycle: clears counters and win_valid; no done pulse; abort beats start in the same cycle.
REQ-030 Counter arithmetic is unsigned CNT_W bits; IMG_W and IMG_H must be < 2^CNT_W.

Reset
REQ-031 rst_n low asynchronously forces IDLE, col_idx=0, row_idx=0, win_valid=0, done=0; s_ready, lb_shift_en and busy then evaluate to 0.
REQ-032 Reset deassertion mid-frame resumes in IDLE; the partial frame is discarded.

Configuration
REQ-033 Macro CONV_CTRL_STALL_CNT_EN defined: adds output stall_cnt, 16 bits, counting cycles with win_valid && !m_ready; saturates at 0xFFFF; cleared by reset and by start in IDLE.
REQ-034 Macro undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification (IMG_W=4, IMG_H=4, KERNEL_SIZE=3, m_ready=1 unless stated)
REQ-035 start, then 16 back-to-back pixels -> first win_valid the cycle after pixel 10 (row 2, col 2); 4 windows total; done pulses once; busy low afterwards.
REQ-036 m_ready held 0 for 5 cycles at the first window -> s_ready=0 and lb_shift_en=0 for those 5 cycles; window count stays 4; stall_cnt=5 when the macro is defined.
REQ-037 s_valid toggling 1,0,1,0 -> counters advance only on accepts; after 16 accepts row_idx=0, col_idx=0, state FLUSH -> IDLE.
REQ-038 abort after pixel 7 -> next cycle IDLE, win_valid=0, counters 0, no done; a new start gives a clean 4-window frame.
REQ-039 rst_n pulsed low mid-RUN -> all outputs reset asynchronously without a clock edge; start during RUN has no effect.

Source files
------------

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl
// Purpose  : Sequencing control for a KERNEL_SIZE x KERNEL_SIZE sliding-window
//            line buffer. It tracks the row and column of the next pixel,
//            enables line-buffer shifts on each accepted pixel, and flags when
//            the buffer holds a complete in-image window. The window is held
//            stable while downstream stalls. A frame runs IDLE -> RUN -> FLUSH
//            -> IDLE, and done pulses when the last window is taken.
// Ports    : clk, rst_n (async, active-low)
//            start, abort               - frame control inputs
//            s_valid / s_ready          - upstream pixel handshake
//            lb_shift_en                - line-buffer shift (= accept)
//            win_valid / m_ready        - downstream window handshake
//            col_idx, row_idx           - position of the next pixel to accept
//            busy, done                 - frame status
//            stall_cnt (optional)       - saturating count of window stalls
// Options  : define CONV_CTRL_STALL_CNT_EN to add the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             lb_shift_en,
  output logic             win_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] col_idx,
  output logic [CNT_W-1:0] row_idx,
  output logic             busy,
  output logic             done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] col_next;
  logic [CNT_W-1:0] row_next;
  logic             win_next;

  logic             accept;
  logic             qualify;
  logic             col_wrap;
  logic             last_px;

  // A pending window that downstream has not taken blocks new pixels,
  // so the line-buffer contents stay frozen under the window.
  assign s_ready     = (state == RUN) && !(win_valid && !m_ready);
  assign accept      = s_valid && s_ready;
  assign lb_shift_en = accept;
  assign busy        = (state != IDLE);

  assign col_wrap = (col_idx == COL_LAST);
  assign last_px  = col_wrap && (row_idx == ROW_LAST);
  // A pixel completes a window only when enough rows and columns are
  // already buffered; column 0..K-2 pixels never qualify, so no window
  // straddles a row wrap.
  assign qualify  = accept && (row_idx >= K_LAST) && (col_idx >= K_LAST);

  always_comb begin
    state_next = state;
    col_next   = col_idx;
    row_next   = row_idx;
    win_next   = win_valid;
    done       = 1'b0;

    if (accept) begin
      if (col_wrap) begin
        col_next = '0;
        row_next = (row_idx == ROW_LAST) ? '0 : row_idx + CNT_W'(1);
      end else begin
        col_next = col_idx + CNT_W'(1);
      end
    end

    // A new qualifying accept in the same cycle as a handshake replaces
    // the consumed window, so the flag stays up.
    if (qualify) begin
      win_next = 1'b1;
    end else if (m_ready) begin
      win_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          col_next   = '0;
          row_next   = '0;
          win_next   = 1'b0;
        end
      end
      RUN: begin
        if (accept && last_px) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (win_valid && m_ready) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including start and the done pulse.
    if (abort) begin
      state_next = IDLE;
      col_next   = '0;
      row_next   = '0;
      win_next   = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_idx   <= '0;
      row_idx   <= '0;
      win_valid <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_next;
      row_idx   <= row_next;
      win_valid <= win_next;
    end
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      stall_cnt <= '0;
    end else if (win_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_ctrl
// Purpose  : Self-checking bench for conv_window_ctrl on a 4x4 image with a
//            3x3 kernel. Stimulus pushes the hand-computed window sequence
//            into a queue; a monitor pops and compares on each window
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

  localparam int KS = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b1;
  logic          s_ready;
  logic          lb_shift_en;
  logic          win_valid;
  logic [CW-1:0] col_idx;
  logic [CW-1:0] row_idx;
  logic          busy;
  logic          done;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  conv_window_ctrl #(
    .KERNEL_SIZE(KS),
    .IMG_W      (W),
    .IMG_H      (H),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .lb_shift_en(lb_shift_en),
    .win_valid  (win_valid),
    .m_ready    (m_ready),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .busy       (busy),
    .done       (done)
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int r, input int c, input bit last);
    exp_t e;
    e.row  = 16'(r);
    e.col  = 16'(c);
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Windows complete at pixels (2,2),(2,3),(3,2),(3,3); at each handshake
  // the counters already point one pixel further on. The last one ends
  // the frame, so done must accompany it.
  task automatic push_frame();
    push_exp(2, 3, 1'b0);
    push_exp(3, 0, 1'b0);
    push_exp(3, 3, 1'b0);
    push_exp(0, 0, 1'b1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && win_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window row %0d col %0d expected none", row_idx, col_idx);
      end else begin
        e = exp_q.pop_front();
        chk("win_row", 32'(row_idx), 32'(e.row));
        chk("win_col", 32'(col_idx), 32'(e.col));
        chk("win_done", 32'(done), 32'(e.last));
      end
    end else if (done) begin
      checks++;
      errors++;
      $display("FAIL stray_done got 1 expected 0 at %0t", $time);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer n pixels; gap inserts idle cycles (s_valid 1,0,1,0...), stall
  // holds m_ready low for that many cycles once the first window appears.
  task automatic drive_pixels(input int n, input bit gap, input int stall);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    bit stalled = 1'b0;
    while (sent < n && cyc < 400) begin
      if (stall > 0 && !stalled && sent == 11) begin
        stalled = 1'b1;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          chk("stall_s_ready", 32'(s_ready), 32'd0);
          chk("stall_shift", 32'(lb_shift_en), 32'd0);
          chk("stall_win", 32'(win_valid), 32'd1);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
      s_valid = gap ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("pixels_accepted", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("row_after", 32'(row_idx), 32'd0);
    chk("col_after", 32'(col_idx), 32'd0);
  endtask

  task automatic run_frame(input bit gap, input int stall);
    push_frame();
    pulse_start();
    drive_pixels(16, gap, stall);
    drain();
  endtask

  initial begin
    // Reset state
    s_valid = 1'b1;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_shift", 32'(lb_shift_en), 32'd0);
    chk("rst_win", 32'(win_valid), 32'd0);
    chk("rst_row", 32'(row_idx), 32'd0);
    chk("rst_col", 32'(col_idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frame
    run_frame(1'b0, 0);

    // Downstream stall at the first window
    run_frame(1'b0, 5);
`ifdef CONV_CTRL_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Gapped input
    run_frame(1'b1, 0);

    // Abort after 7 pixels
    pulse_start();
    drive_pixels(7, 1'b0, 0);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_win", 32'(win_valid), 32'd0);
    chk("abort_row", 32'(row_idx), 32'd0);
    chk("abort_col", 32'(col_idx), 32'd0);
    @(posedge clk); #1;
    run_frame(1'b0, 0);

    // Start ignored in RUN, then asynchronous reset mid-frame
    pulse_start();
    drive_pixels(5, 1'b0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("run_start_row", 32'(row_idx), 32'd1);
    chk("run_start_col", 32'(col_idx), 32'd1);
    chk("run_start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_shift", 32'(lb_shift_en), 32'd0);
    chk("arst_row", 32'(row_idx), 32'd0);
    chk("arst_col", 32'(col_idx), 32'd0);
    chk("arst_win", 32'(win_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_frame(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
